// File: rtl/ifid_fetch_ctrl_pkg.sv
// Shared opcode encodings, controller state and register-source decode for
// the IF/ID fetch controller and its hazard unit.
package ifid_fetch_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // SHF is treated like the other single-source ops so the check stays conservative.
  function automatic logic reads_reg(input logic [WORD_W-1:0] word, input logic [2:0] r);
    logic hit86;
    logic hit20;
    logic hit119;
    logic rd;
    hit86  = (word[8:6] == r);
    hit20  = (word[2:0] == r);
    hit119 = (word[11:9] == r);
    case (lc3b_opcode'(word[15:12]))
      OP_ADD, OP_AND:                            rd = hit86 || (!word[5] && hit20);
      OP_NOT, OP_LDB, OP_LDR, OP_LDI,
      OP_JMP, OP_SHF:                            rd = hit86;
      OP_JSR:                                    rd = !word[11] && hit86;
      OP_STB, OP_STR, OP_STI:                    rd = hit86 || hit119;
      default:                                   rd = 1'b0;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/ifid_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, the imem port, the PC and
// the IF/ID register.
interface ifid_fetch_ctrl_if #(parameter int STALL_CNT_W = 16);
  import ifid_fetch_ctrl_pkg::*;

  logic                   imem_resp;
  logic [WORD_W-1:0]      imem_rdata;
  logic                   imem_read;
  logic                   pc_load;
  logic                   id_ready;
  logic [3:0]             id_opcode;
  logic [2:0]             id_dest;
  logic                   flush;
  logic                   ifid_load;
  logic [WORD_W-1:0]      ifid_word;
  logic                   ifid_valid;
  logic                   hazard_stall;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    input  imem_resp, imem_rdata, id_ready, id_opcode, id_dest, flush,
    output imem_read, pc_load, ifid_load, ifid_word, ifid_valid, hazard_stall, stall_cnt
  );

  modport slave (
    output imem_resp, imem_rdata, id_ready, id_opcode, id_dest, flush,
    input  imem_read, pc_load, ifid_load, ifid_word, ifid_valid, hazard_stall, stall_cnt
  );

endinterface

// File: rtl/ifid_fetch_ctrl_hazard_unit.sv
// Load-use detector: flags a word that sources the destination of a load
// currently sitting in IF/ID.
module ifid_hazard_unit
  import ifid_fetch_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [3:0]        i_id_opcode,
  input  logic [2:0]        i_id_dest,
  input  logic              i_ifid_valid,
  output logic              o_haz
);

  logic w_is_load;

  assign w_is_load = (i_id_opcode == OP_LDB) ||
                     (i_id_opcode == OP_LDR) ||
                     (i_id_opcode == OP_LDI);

  assign o_haz = i_ifid_valid && w_is_load && reads_reg(i_word, i_id_dest);

endmodule

// File: rtl/ifid_fetch_ctrl.sv
// Fetch sequencer for the IF/ID register: imem handshake, one-word skid
// buffer, load-use bubble insertion and branch flush handling.
module ifid_fetch_ctrl
  import ifid_fetch_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  ifid_fetch_ctrl_if.master bus
);

  fetch_state_e           r_state;
  logic                   r_run;
  logic                   r_imem_read;
  logic                   r_ifid_valid;
  logic                   r_discard;
  logic [WORD_W-1:0]      r_buf;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic              w_in_fetch;
  logic              w_resp_ok;
  logic              w_avail;
  logic              w_adv;
  logic              w_haz;
  logic [WORD_W-1:0] w_word;

  assign w_in_fetch = (r_state == FETCH);
  assign w_resp_ok  = w_in_fetch && r_imem_read && bus.imem_resp && !r_discard;
  assign w_avail    = w_resp_ok || (r_state == HOLD);
  assign w_word     = (r_state == HOLD) ? r_buf : bus.imem_rdata;
  assign w_adv      = !r_ifid_valid || bus.id_ready;

  ifid_hazard_unit u_hazard (
    .i_word       (w_word),
    .i_id_opcode  (bus.id_opcode),
    .i_id_dest    (bus.id_dest),
    .i_ifid_valid (r_ifid_valid),
    .o_haz        (w_haz)
  );

  // r_run keeps every pulse output quiet until the first edge after reset.
  assign bus.imem_read    = r_imem_read;
  assign bus.pc_load      = r_run && !bus.flush && w_resp_ok;
  assign bus.ifid_load    = r_run && (bus.flush || w_adv);
  assign bus.ifid_word    = w_word;
  assign bus.ifid_valid   = r_ifid_valid;
  assign bus.hazard_stall = r_run && !bus.flush && w_avail && w_adv && w_haz;
  assign bus.stall_cnt    = r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FETCH;
      r_run        <= 1'b0;
      r_imem_read  <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_discard    <= 1'b0;
      r_buf        <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_run       <= 1'b1;
      r_imem_read <= 1'b1;
      if (bus.flush) begin
        // A request still in flight must have its response thrown away.
        r_state      <= FETCH;
        r_ifid_valid <= 1'b0;
        r_discard    <= w_in_fetch && r_imem_read && !bus.imem_resp;
      end else begin
        if (w_in_fetch && bus.imem_resp) begin
          r_discard <= 1'b0;
        end
        if (w_avail) begin
          if (w_adv && !w_haz) begin
            r_state      <= FETCH;
            r_ifid_valid <= 1'b1;
          end else begin
            r_state     <= HOLD;
            r_imem_read <= 1'b0;
            r_buf       <= w_word;
            if (w_adv) begin
              r_ifid_valid <= 1'b0;
            end else if (r_stall_cnt != '1) begin
              r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
          end
        end else if (w_adv) begin
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifid_fetch_ctrl.sv
// Scoreboard bench for ifid_fetch_ctrl: directed fetch sequences push the
// expected IF/ID events; a monitor pops and compares whatever the DUT emits.
module tb_ifid_fetch_ctrl;

  typedef struct packed {
    logic        pc;
    logic        haz;
    logic        ld;
    logic [15:0] word;
  } ev_t;

  logic clk;
  logic reset_n;
  int   nChecks;
  int   nFail;
  ev_t  expQ[$];

  logic [15:0] ifidReg;
  logic        smRun;
  logic        smLoad;
  logic        smPc;
  logic        smHaz;
  logic [15:0] smWord;

  ifid_fetch_ctrl_if #(.STALL_CNT_W(16)) bus ();

  ifid_fetch_ctrl #(.STALL_CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment model of the IF/ID register feeding opcode/dest back to the DUT.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ifidReg <= '0;
    else if (bus.ifid_load) ifidReg <= bus.ifid_word;
  end
  assign bus.id_opcode = ifidReg[15:12];
  assign bus.id_dest   = ifidReg[11:9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expectEvent(input logic pc, input logic haz, input logic ld, input logic [15:0] word);
    ev_t e;
    e.pc = pc; e.haz = haz; e.ld = ld; e.word = word;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic resp, input logic [15:0] data, input logic ready, input logic fl);
    bus.imem_resp  = resp;
    bus.imem_rdata = data;
    bus.id_ready   = ready;
    bus.flush      = fl;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    smRun  <= reset_n;
    smLoad <= bus.ifid_load;
    smPc   <= bus.pc_load;
    smHaz  <= bus.hazard_stall;
    smWord <= bus.ifid_word;
  end

  // An event is any pc_load, hazard bubble, or load of a real instruction.
  always begin
    ev_t act;
    ev_t exp;
    @(posedge clk);
    #1;
    if (smRun === 1'b1 && (smPc || smHaz || (smLoad && bus.ifid_valid))) begin
      act.pc = smPc; act.haz = smHaz; act.ld = smLoad && bus.ifid_valid; act.word = smWord;
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_event: got %h, expected none", act);
      end else begin
        exp = expQ.pop_front();
        checkOutput("event", 32'(act), 32'(exp));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    reset_n = 1'b0;
    bus.imem_resp = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1; bus.flush = 1'b0;
    #1;
    checkOutput("reset_imem_read", 32'(bus.imem_read), 32'd0);
    checkOutput("reset_ifid_valid", 32'(bus.ifid_valid), 32'd0);
    checkOutput("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_imem_read", 32'(bus.imem_read), 32'd1);

    // Straight line: one ADD every two cycles.
    for (int i = 0; i < 3; i++) begin
      expectEvent(1'b1, 1'b0, 1'b1, 16'h1283);
      applyStimulus(1'b1, 16'h1283, 1'b1, 1'b0);
      checkOutput("straight_valid", 32'(bus.ifid_valid), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checkOutput("straight_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Load-use: LDR R1 then ADD R2,R1,#1.
    expectEvent(1'b1, 1'b0, 1'b1, 16'h6200);
    applyStimulus(1'b1, 16'h6200, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b1, 1'b0, 16'h1461);
    applyStimulus(1'b1, 16'h1461, 1'b1, 1'b0);
    checkOutput("loaduse_bubble_valid", 32'(bus.ifid_valid), 32'd0);
    checkOutput("loaduse_hold_imem_read", 32'(bus.imem_read), 32'd0);
    expectEvent(1'b0, 1'b0, 1'b1, 16'h1461);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("loaduse_after_valid", 32'(bus.ifid_valid), 32'd1);

    // No false hazards: independent source, BR, and ADD (non-load) in IF/ID.
    expectEvent(1'b1, 1'b0, 1'b1, 16'h6200);
    applyStimulus(1'b1, 16'h6200, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h14E1);
    applyStimulus(1'b1, 16'h14E1, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h6200);
    applyStimulus(1'b1, 16'h6200, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h0E05);
    applyStimulus(1'b1, 16'h0E05, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h1283);
    applyStimulus(1'b1, 16'h1283, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h1461);
    applyStimulus(1'b1, 16'h1461, 1'b1, 1'b0);

    // Downstream stall for five cycles with a word arriving on the first.
    expectEvent(1'b1, 1'b0, 1'b0, 16'h14E1);
    applyStimulus(1'b1, 16'h14E1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("stall_imem_read", 32'(bus.imem_read), 32'd0);
    checkOutput("stall_cnt_5", 32'(bus.stall_cnt), 32'd5);
    expectEvent(1'b0, 1'b0, 1'b1, 16'h14E1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("stall_release_cnt", 32'(bus.stall_cnt), 32'd5);
    checkOutput("stall_release_imem_read", 32'(bus.imem_read), 32'd1);

    // Flush while waiting; the in-flight response three cycles later is dropped.
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("flush_imem_read", 32'(bus.imem_read), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h1283, 1'b1, 1'b0);
    checkOutput("flush_drop_valid", 32'(bus.ifid_valid), 32'd0);
    checkOutput("flush_drop_imem_read", 32'(bus.imem_read), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h14E1);
    applyStimulus(1'b1, 16'h14E1, 1'b1, 1'b0);
    // Flush coincident with a response: dropped, nothing left pending.
    applyStimulus(1'b1, 16'h1461, 1'b1, 1'b1);
    checkOutput("flush_coinc_valid", 32'(bus.ifid_valid), 32'd0);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h1283);
    applyStimulus(1'b1, 16'h1283, 1'b1, 1'b0);
    checkOutput("flush_keeps_stall_cnt", 32'(bus.stall_cnt), 32'd5);

    // Reset asserted while a word sits in the skid buffer.
    expectEvent(1'b1, 1'b0, 1'b0, 16'h0E05);
    applyStimulus(1'b1, 16'h0E05, 1'b0, 1'b0);
    bus.imem_resp = 1'b0; bus.id_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_ifid_valid", 32'(bus.ifid_valid), 32'd0);
    checkOutput("midreset_imem_read", 32'(bus.imem_read), 32'd0);
    checkOutput("midreset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rerelease_imem_read", 32'(bus.imem_read), 32'd1);
    expectEvent(1'b1, 1'b0, 1'b1, 16'h6200);
    applyStimulus(1'b1, 16'h6200, 1'b1, 1'b0);
    checkOutput("rerelease_valid", 32'(bus.ifid_valid), 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/ifid_fetch_ctrl.md
Name: ifid_fetch_ctrl

Overview:
- Sequences the instruction fetch into the IF/ID instruction register that feeds opcode/dest/src1/src2/ir_10_0 decode.
- Owns the imem read handshake and a one-word skid buffer.
- Drives the IF/ID load enable and valid bit; inserts one bubble on a load-use hazard and discards work on a branch flush.
- Sits between the PC/imem port and the IF/ID register; it has no datapath arithmetic beyond field compares.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  16  fetched instruction word.
- imem_read  out  1  read request; held high until imem_resp.
- pc_load  out  1  PC <- PC+2; pulses when a fetched word is accepted (buffered or loaded).
- id_ready  in  1  ID stage advances to EX this cycle.
- id_opcode  in  4  opcode currently in IF/ID.
- id_dest  in  3  dest field currently in IF/ID.
- flush  in  1  taken branch/jump from EX; the datapath loads the target PC itself.
- ifid_load  out  1  load enable for the IF/ID register.
- ifid_word  out  16  word presented to IF/ID (skid buffer if full, else imem_rdata).
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- hazard_stall  out  1  load-use bubble is being inserted this cycle.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with a word available but not loaded.

Behaviour:
- Reset (async, reset_n=0):
  - State FETCH; imem_read=0 during reset, 1 from the first cycle after release.
  - ifid_valid=0, buffer empty, discard_pend=0, stall_cnt=0.
  - All pulse outputs 0.
- States:
  - FETCH: imem_read=1, waiting for imem_resp.
  - HOLD: a word is in the skid buffer; imem_read=0.
- Word available (avail) = (FETCH && imem_resp && !discard_pend) || HOLD.
- Advance condition: adv = !ifid_valid || id_ready.
- Load-use hazard (haz):
  - Requires ifid_valid, id_opcode in {LDB 0010, LDR 0110, LDI 1010}, and the available word reads id_dest.
  - Sources read by the available word:
    - ADD/AND read [8:6]; they also read [2:0] when bit5=0.
    - NOT, LDB, LDR, LDI, JMP/RET, JSRR (bit11=0), STB/STR/STI read [8:6].
    - STB/STR/STI also read [11:9].
    - BR, JSR (bit11=1), LEA, TRAP, RTI read no registers.
- Each cycle, when flush=0:
  - avail && adv && !haz:
    - ifid_load=1, ifid_valid<=1, state<=FETCH.
    - pc_load=1 only if the word came directly from imem_resp; a buffered word already pulsed pc_load.
  - avail && adv && haz:
    - ifid_load=1 with ifid_valid<=0 (bubble); hazard_stall=1.
    - The word moves to or stays in the buffer; state<=HOLD.
  - avail && !adv:
    - The word moves to or stays in the buffer; state<=HOLD; stall_cnt++ (saturating).
  - A word arriving via imem_resp into the buffer pulses pc_load that same cycle.
  - !avail && adv: ifid_load=1, ifid_valid<=0 (drain to a bubble).
- flush=1 (highest priority, overrides everything above):
  - ifid_load=1, ifid_valid<=0; buffer emptied; state<=FETCH; pc_load=0.
  - If in FETCH with no imem_resp this cycle, set discard_pend=1.
  - The next imem_resp is then dropped (no pc_load) and clears discard_pend; imem_read stays 1 for the refetch.
  - flush coincident with imem_resp: that response is dropped; discard_pend stays 0.
- Latency:
  - Word present on imem_resp with no hazard/stall is in IF/ID at the next clk edge (0 bubbles).
  - A load-use hazard costs exactly 1 bubble.
- stall_cnt saturates at all-ones and is not cleared by flush.
- Reset assertion mid-handshake abandons the request immediately; the first response after reset is accepted normally.

Decomposition:
- Shared package:
  - Opcode constants (existing lc3b_opcode enum).
  - A function reads_reg(word, reg) returning whether the word sources reg.
  - A typedef for the controller state enum {FETCH, HOLD}.
- Sub-module: ifid_hazard_unit, combinational. Inputs are the word, id_opcode, id_dest and ifid_valid; output is haz. It is kept separate so it can be reused by the ID/EX controller.

Test Plan:
- Straight line: resp every 2 cycles with ADD R1,R2,R3 (0x1283), id_ready=1 -> ifid_load with ifid_valid=1 one edge after each resp; pc_load pulses 1 per word; stall_cnt=0.
- Load-use: IF/ID holds LDR R1,R0,#0 (0x6200); fetch ADD R2,R1,#1 (0x1461) -> hazard_stall=1 for 1 cycle and ifid_valid=0 for 1 cycle; ADD loaded the next cycle; pc_load pulses exactly once.
- No false hazard: IF/ID holds LDR R1; fetch ADD R2,R3,#1 (0x14E1) -> no bubble. Likewise with BR 0x0E05 and with the IF/ID holding ADD -> no bubble.
- Downstream stall: id_ready=0 for 5 cycles while ifid_valid=1 and a resp arrives -> state HOLD, imem_read=0, stall_cnt=5. On id_ready=1 the buffered word loads; pc_load does not pulse again.
- Flush in flight: flush while FETCH waits; resp 3 cycles later -> word dropped, no pc_load, ifid_valid stays 0, imem_read stays 1; the next resp loads normally.
- Reset mid-HOLD: reset_n low asynchronously -> ifid_valid=0, imem_read=0 immediately; after release imem_read=1 and the first resp is accepted.
